// File: rtl/minmax_reduce_sequencer.sv
// Sequences one min-max reduction job: command -> N operand beats -> one result.
// Latency: result valid the cycle after the last beat (or after the command if len=0).
// Backpressure: valid/ready on cmd, op and res streams; one job in flight, result held until res_ready.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   cmd_valid/ready command handshake; cmd_len beats, cmd_init initial accumulator
//   op_valid/ready  operand beat handshake; op_data = {d2,d1,c2,c1,b2,b1,a2,a1}
//   res_valid/ready result handshake; res_data = accumulator
//   busy            high while a job is running or its result is pending
module minmax_reduce_sequencer #(
   parameter int W     = 16,
   parameter int LEN_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [W-1:0]       cmd_init,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [8*W-1:0]     op_data,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [W-1:0]       res_data,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t             state;
   logic [W-1:0]       acc;
   logic [LEN_W-1:0]   cnt;

   logic [W-1:0] a1, a2, b1, b2, c1, c2, d1, d2;
   logic [W-1:0] min_a, min_b, min_c, min_d;
   logic [W-1:0] max_ab, max_cd, beat_v, acc_next;

   assign a1 = op_data[0*W +: W];
   assign a2 = op_data[1*W +: W];
   assign b1 = op_data[2*W +: W];
   assign b2 = op_data[3*W +: W];
   assign c1 = op_data[4*W +: W];
   assign c2 = op_data[5*W +: W];
   assign d1 = op_data[6*W +: W];
   assign d2 = op_data[7*W +: W];

   // Beat reduction tree (unsigned compares): min of lane pairs, max of pairs, min of halves.
   assign min_a    = (a1 < a2) ? a1 : a2;
   assign min_b    = (b1 < b2) ? b1 : b2;
   assign min_c    = (c1 < c2) ? c1 : c2;
   assign min_d    = (d1 < d2) ? d1 : d2;
   assign max_ab   = (min_a > min_b) ? min_a : min_b;
   assign max_cd   = (min_c > min_d) ? min_c : min_d;
   assign beat_v   = (max_ab < max_cd) ? max_ab : max_cd;
   assign acc_next = (acc < beat_v) ? acc : beat_v;

   assign res_data = acc;

   // Handshake outputs are registered alongside the state so they are glitch-free
   // and always match the state decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         op_ready  <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  acc       <= cmd_init;
                  cnt       <= cmd_len;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_len == '0) begin
                     state     <= OUT;
                     res_valid <= 1'b1;
                  end else begin
                     state    <= RUN;
                     op_ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               // cnt is at least 1 in RUN, so the decrement cannot wrap.
               if (op_valid && op_ready && cnt != '0) begin
                  acc <= acc_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == LEN_W'(1)) begin
                     state     <= OUT;
                     op_ready  <= 1'b0;
                     res_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               op_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
